sys_cmd_ctrl: RTL and testbench

Parametrised frame-command controller between the UART RX data-sync output, the register file, the ALU and the TX async FIFO.
- Decodes opcode frames and drives register-file write/read, ALU operand load and execution, and multi-byte result return into the TX FIFO.
- Supersedes the fixed 8-bit single-access controller.
- Adds burst read/write with address auto-increment, width-generic ALU result return, an inter-byte timeout watchdog and error flagging.

---
 rtl/sys_cmd_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_sys_cmd_ctrl.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_cmd_ctrl.sv
// rtl/sys_cmd_ctrl.sv - frame-command controller: UART RX frames to regfile/ALU, results to TX FIFO
// Optional CMD_ERR_RESP_EN: every error also pushes a 0xE0 byte to the TX FIFO via ERR_SEND.
module sys_cmd_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int ALU_OUT_W   = 16,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX_ENABLE,
  input  logic [DATA_W-1:0]    RX_P_DATA,
  input  logic [DATA_W-1:0]    Rd_Data,
  input  logic                 Rd_Data_Valid,
  input  logic [ALU_OUT_W-1:0] ALU_OUT,
  input  logic                 ALU_Valid,
  input  logic                 FIFO_FULL,
  output logic                 Wr_En,
  output logic                 Rd_En,
  output logic [ADDR_W-1:0]    Address,
  output logic [DATA_W-1:0]    Wr_Data,
  output logic                 ALU_EN,
  output logic [3:0]           ALU_FUN,
  output logic                 CLK_EN,
  output logic                 TX_D_VLD,
  output logic [DATA_W-1:0]    TX_P_DATA,
  output logic                 cmd_err,
  output logic                 busy
);

  localparam int NBYTES = ALU_OUT_W / DATA_W;
  localparam int NB_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int WD_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit WD_ON  = (TIMEOUT_CYC > 0);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [NB_W-1:0]   NB_LAST  = NB_W'(NBYTES - 1);
  localparam logic [DATA_W:0]   BEAT_ONE = {{DATA_W{1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] OP_WR    = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] OP_RD    = DATA_W'(8'hBB);
  localparam logic [DATA_W-1:0] OP_ALU   = DATA_W'(8'hCC);
  localparam logic [DATA_W-1:0] OP_NOP   = DATA_W'(8'hDD);
  localparam logic [DATA_W-1:0] OP_BWR   = DATA_W'(8'hEE);
  localparam logic [DATA_W-1:0] OP_BRD   = DATA_W'(8'hFF);
`ifdef CMD_ERR_RESP_EN
  localparam logic [DATA_W-1:0] ERR_BYTE = DATA_W'(8'hE0);
`endif

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_CNT, WR_DATA, RD_REQ, RD_WAIT, RD_SEND,
    OP_A, OP_B, FUN, ALU_WAIT, ALU_SEND, ERR_SEND
  } state_t;

  state_t                state, state_n;
  logic [ADDR_W-1:0]     addr_q, addr_n;
  logic [DATA_W:0]       beats_q, beats_n;
  logic [DATA_W-1:0]     hold_q, hold_n;
  logic [ALU_OUT_W-1:0]  alu_q, alu_n;
  logic [NB_W-1:0]       left_q, left_n;
  logic [WD_W-1:0]       wd_q, wd_n;
  logic                  rd_op_q, rd_op_n, burst_q, burst_n;
  logic                  wr_en_n, rd_en_n, alu_en_n, clk_en_n, tx_vld_n, err_n, busy_n;
  logic [ADDR_W-1:0]     address_n;
  logic [DATA_W-1:0]     wr_data_n, tx_data_n;
  logic [3:0]            alu_fun_n;
  logic                  rx_take, err_route, progress;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      addr_q    <= '0;
      beats_q   <= '0;
      hold_q    <= '0;
      alu_q     <= '0;
      left_q    <= '0;
      wd_q      <= '0;
      rd_op_q   <= 1'b0;
      burst_q   <= 1'b0;
      Wr_En     <= 1'b0;
      Rd_En     <= 1'b0;
      Address   <= '0;
      Wr_Data   <= '0;
      ALU_EN    <= 1'b0;
      ALU_FUN   <= '0;
      CLK_EN    <= 1'b0;
      TX_D_VLD  <= 1'b0;
      TX_P_DATA <= '0;
      cmd_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      addr_q    <= addr_n;
      beats_q   <= beats_n;
      hold_q    <= hold_n;
      alu_q     <= alu_n;
      left_q    <= left_n;
      wd_q      <= wd_n;
      rd_op_q   <= rd_op_n;
      burst_q   <= burst_n;
      Wr_En     <= wr_en_n;
      Rd_En     <= rd_en_n;
      Address   <= address_n;
      Wr_Data   <= wr_data_n;
      ALU_EN    <= alu_en_n;
      ALU_FUN   <= alu_fun_n;
      CLK_EN    <= clk_en_n;
      TX_D_VLD  <= tx_vld_n;
      TX_P_DATA <= tx_data_n;
      cmd_err   <= err_n;
      busy      <= busy_n;
    end
  end

  always_comb begin
    state_n   = state;
    addr_n    = addr_q;
    beats_n   = beats_q;
    hold_n    = hold_q;
    alu_n     = alu_q;
    left_n    = left_q;
    rd_op_n   = rd_op_q;
    burst_n   = burst_q;
    wr_en_n   = 1'b0;
    rd_en_n   = 1'b0;
    alu_en_n  = 1'b0;
    tx_vld_n  = 1'b0;
    err_n     = 1'b0;
    address_n = Address;
    wr_data_n = Wr_Data;
    alu_fun_n = ALU_FUN;
    clk_en_n  = CLK_EN;
    tx_data_n = TX_P_DATA;
    rx_take   = 1'b0;
    err_route = 1'b0;

    case (state)
      IDLE: begin
        clk_en_n = 1'b0;
        if (RX_ENABLE) begin
          rx_take = 1'b1;
          case (RX_P_DATA)
            OP_WR:   begin state_n = GET_ADDR; rd_op_n = 1'b0; burst_n = 1'b0; end
            OP_RD:   begin state_n = GET_ADDR; rd_op_n = 1'b1; burst_n = 1'b0; end
            OP_BWR:  begin state_n = GET_ADDR; rd_op_n = 1'b0; burst_n = 1'b1; end
            OP_BRD:  begin state_n = GET_ADDR; rd_op_n = 1'b1; burst_n = 1'b1; end
            OP_ALU:  state_n = OP_A;
            OP_NOP:  begin state_n = FUN; clk_en_n = 1'b1; end
            default: err_route = 1'b1;
          endcase
        end
      end
      GET_ADDR: if (RX_ENABLE) begin
        rx_take = 1'b1;
        addr_n  = RX_P_DATA[ADDR_W-1:0];
        if (burst_q) begin
          state_n = GET_CNT;
        end else begin
          beats_n = BEAT_ONE;
          state_n = rd_op_q ? RD_REQ : WR_DATA;
        end
      end
      GET_CNT: if (RX_ENABLE) begin
        rx_take = 1'b1;
        beats_n = {1'b0, RX_P_DATA} + BEAT_ONE;
        state_n = rd_op_q ? RD_REQ : WR_DATA;
      end
      WR_DATA: if (RX_ENABLE) begin
        rx_take   = 1'b1;
        wr_en_n   = 1'b1;
        address_n = addr_q;
        wr_data_n = RX_P_DATA;
        addr_n    = addr_q + ADDR_W'(1);
        if (beats_q == BEAT_ONE) state_n = IDLE;
        else                     beats_n = beats_q - BEAT_ONE;
      end
      RD_REQ: begin
        rd_en_n   = 1'b1;
        address_n = addr_q;
        state_n   = RD_WAIT;
      end
      RD_WAIT: if (Rd_Data_Valid) begin
        hold_n  = Rd_Data;
        state_n = RD_SEND;
      end
      RD_SEND: if (!FIFO_FULL) begin
        tx_vld_n  = 1'b1;
        tx_data_n = hold_q;
        if (beats_q == BEAT_ONE) begin
          state_n = IDLE;
        end else begin
          beats_n = beats_q - BEAT_ONE;
          addr_n  = addr_q + ADDR_W'(1);
          state_n = RD_REQ;
        end
      end
      OP_A: if (RX_ENABLE) begin
        rx_take   = 1'b1;
        wr_en_n   = 1'b1;
        address_n = '0;
        wr_data_n = RX_P_DATA;
        state_n   = OP_B;
      end
      OP_B: if (RX_ENABLE) begin
        rx_take   = 1'b1;
        wr_en_n   = 1'b1;
        address_n = ADDR_W'(1);
        wr_data_n = RX_P_DATA;
        clk_en_n  = 1'b1;
        state_n   = FUN;
      end
      FUN: if (RX_ENABLE) begin
        rx_take   = 1'b1;
        alu_en_n  = 1'b1;
        alu_fun_n = RX_P_DATA[3:0];
        state_n   = ALU_WAIT;
      end
      ALU_WAIT: if (ALU_Valid) begin
        alu_n   = ALU_OUT;
        left_n  = NB_LAST;
        state_n = ALU_SEND;
      end
      // Result leaves LSB first; CLK_EN falls in IDLE, one cycle after the last byte.
      ALU_SEND: if (!FIFO_FULL) begin
        tx_vld_n  = 1'b1;
        tx_data_n = alu_q[DATA_W-1:0];
        alu_n     = alu_q >> DATA_W;
        if (left_q == '0) state_n = IDLE;
        else              left_n  = left_q - NB_W'(1);
      end
`ifdef CMD_ERR_RESP_EN
      ERR_SEND: if (!FIFO_FULL) begin
        tx_vld_n  = 1'b1;
        tx_data_n = ERR_BYTE;
        state_n   = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase

    // Every RX-waiting state consumes its byte, so anything left untaken is a stray byte.
    if (RX_ENABLE && !rx_take && state != IDLE) err_route = 1'b1;

    if (err_route) begin
      err_n = 1'b1;
`ifdef CMD_ERR_RESP_EN
      state_n  = ERR_SEND;
      clk_en_n = 1'b0;
      wr_en_n  = 1'b0;
      rd_en_n  = 1'b0;
      alu_en_n = 1'b0;
      tx_vld_n = 1'b0;
`endif
    end

    progress = rx_take || (state_n != state);
    wd_n     = (state == IDLE || progress) ? '0 : wd_q + WD_W'(1);

    if (WD_ON && state != IDLE && !progress && wd_q == WD_LAST) begin
      state_n  = IDLE;
`ifdef CMD_ERR_RESP_EN
      if (state != ERR_SEND) state_n = ERR_SEND;
`endif
      wd_n     = '0;
      err_n    = 1'b1;
      clk_en_n = 1'b0;
      wr_en_n  = 1'b0;
      rd_en_n  = 1'b0;
      alu_en_n = 1'b0;
      tx_vld_n = 1'b0;
    end

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// tb/tb_sys_cmd_ctrl.sv - randomized self-checking bench for sys_cmd_ctrl against a frame-level model
module tb_sys_cmd_ctrl;
  localparam int TO = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        RX_ENABLE = 1'b0;
  logic [7:0]  RX_P_DATA = '0;
  logic [7:0]  Rd_Data = '0;
  logic        Rd_Data_Valid = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_Valid = 1'b0;
  logic        fifo_force = 1'b0;
  logic        fifo_rand = 1'b0;
  logic        rand_en = 1'b0;
  wire         FIFO_FULL = fifo_force | fifo_rand;
  logic        Wr_En, Rd_En, ALU_EN, CLK_EN, TX_D_VLD, cmd_err, busy;
  logic [3:0]  Address, ALU_FUN;
  logic [7:0]  Wr_Data, TX_P_DATA;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int strobe_cyc = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int full_viol = 0;
  logic fifo_prev = 1'b0;

  logic [7:0]  env_regs [16];
  logic [7:0]  model_regs [16];
  logic [11:0] wr_log [$];
  int          wr_cyc [$];
  logic        wr_clk [$];
  logic [7:0]  tx_log [$];
  logic        tx_clk [$];
  logic [3:0]  fun_log [$];

  sys_cmd_ctrl #(.DATA_W(8), .ADDR_W(4), .ALU_OUT_W(16), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RST(RST), .RX_ENABLE(RX_ENABLE), .RX_P_DATA(RX_P_DATA),
    .Rd_Data(Rd_Data), .Rd_Data_Valid(Rd_Data_Valid), .ALU_OUT(ALU_OUT),
    .ALU_Valid(ALU_Valid), .FIFO_FULL(FIFO_FULL), .Wr_En(Wr_En), .Rd_En(Rd_En),
    .Address(Address), .Wr_Data(Wr_Data), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .CLK_EN(CLK_EN), .TX_D_VLD(TX_D_VLD), .TX_P_DATA(TX_P_DATA),
    .cmd_err(cmd_err), .busy(busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) fifo_prev <= FIFO_FULL;

  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      4'd0:    return {8'h00, a} + {8'h00, b};
      4'd1:    return {8'h00, a} - {8'h00, b};
      4'd2:    return {8'h00, a} * {8'h00, b};
      4'd3:    return {a, b};
      default: return {8'h00, a ^ b};
    endcase
  endfunction

  // Observation log plus a register-file model that absorbs DUT writes.
  always @(negedge CLK) begin
    if (Wr_En) begin
      wr_log.push_back({Address, Wr_Data});
      wr_cyc.push_back(cyc);
      wr_clk.push_back(CLK_EN);
      env_regs[Address] = Wr_Data;
    end
    if (TX_D_VLD) begin
      tx_log.push_back(TX_P_DATA);
      tx_clk.push_back(CLK_EN);
      if (fifo_prev) full_viol = full_viol + 1;
    end
    if (ALU_EN) fun_log.push_back(ALU_FUN);
    if (cmd_err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
  end

  initial forever begin
    logic [3:0] ra;
    @(negedge CLK);
    if (Rd_En) begin
      ra = Address;
      repeat (2) @(negedge CLK);
      Rd_Data = env_regs[ra];
      Rd_Data_Valid = 1'b1;
      @(negedge CLK);
      Rd_Data_Valid = 1'b0;
    end
  end

  initial forever begin
    logic [3:0] f;
    @(negedge CLK);
    if (ALU_EN) begin
      f = ALU_FUN;
      repeat (3) @(negedge CLK);
      ALU_OUT = alu_ref(env_regs[0], env_regs[1], f);
      ALU_Valid = 1'b1;
      @(negedge CLK);
      ALU_Valid = 1'b0;
    end
  end

  initial forever begin
    @(negedge CLK);
    fifo_rand = rand_en ? ($urandom_range(0, 3) == 0) : 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "bench stalled");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge CLK);
    RX_P_DATA = b;
    RX_ENABLE = 1'b1;
    strobe_cyc = cyc;
    @(negedge CLK);
    RX_ENABLE = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge CLK);
    total++;
    if ({Wr_En, Rd_En, Address, Wr_Data, ALU_EN, ALU_FUN, CLK_EN, TX_D_VLD, TX_P_DATA, cmd_err, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %b, want all zero",
               {Wr_En, Rd_En, Address, Wr_Data, ALU_EN, ALU_FUN, CLK_EN, TX_D_VLD, TX_P_DATA, cmd_err, busy});
    end
    RST = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_single_write;
    int wb, sc;
    bit ok;
    wb = wr_log.size();
    send_byte(8'hAA, 0);
    send_byte(8'h05, 0);
    send_byte(8'h3C, 0);
    sc = strobe_cyc;
    wait_idle(ok);
    model_regs[5] = 8'h3C;
    total++;
    if (!ok) begin bad++; $display("FAIL single_write_idle: busy never dropped"); end
    total++;
    if (wr_log.size() - wb != 1) begin
      bad++; $display("FAIL single_write_count: got %0d, want 1", wr_log.size() - wb);
    end else begin
      total++;
      if (wr_log[wb] !== {4'h5, 8'h3C}) begin
        bad++; $display("FAIL single_write_data: got %h, want 53c", wr_log[wb]);
      end
      total++;
      if (wr_cyc[wb] != sc + 1) begin
        bad++; $display("FAIL single_write_latency: got cycle %0d, want %0d", wr_cyc[wb], sc + 1);
      end
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_write_busy: got %b, want 0", busy); end
  endtask

  task automatic test_burst_wrap;
    int wb;
    bit ok;
    logic [11:0] exp [$];
    wb = wr_log.size();
    exp = '{ {4'hE, 8'h11}, {4'hF, 8'h22}, {4'h0, 8'h33} };
    send_byte(8'hEE, 0);
    send_byte(8'h0E, 1);
    send_byte(8'h02, 0);
    send_byte(8'h11, 2);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    wait_idle(ok);
    model_regs[14] = 8'h11; model_regs[15] = 8'h22; model_regs[0] = 8'h33;
    total++;
    if (!ok || wr_log.size() - wb != 3) begin
      bad++; $display("FAIL burst_wrap_count: got %0d, want 3 (idle=%0d)", wr_log.size() - wb, ok);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (wr_log[wb + i] !== exp[i]) begin
          bad++; $display("FAIL burst_wrap_beat%0d: got %h, want %h", i, wr_log[wb + i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_burst_read;
    int tb, fv;
    bit ok, seen;
    tb = tx_log.size();
    fv = full_viol;
    send_byte(8'hEE, 0); send_byte(8'h02, 0); send_byte(8'h01, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    wait_idle(ok);
    model_regs[2] = 8'hAA; model_regs[3] = 8'hBB;
    send_byte(8'hFF, 0);
    send_byte(8'h02, 0);
    send_byte(8'h01, 0);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (tx_log.size() - tb >= 1) begin seen = 1'b1; break; end
    end
    fifo_force = 1'b1;
    repeat (5) @(negedge CLK);
    total++;
    if (!seen || tx_log.size() - tb != 1) begin
      bad++; $display("FAIL burst_read_stall: got %0d bytes during full, want 1", tx_log.size() - tb);
    end
    fifo_force = 1'b0;
    wait_idle(ok);
    total++;
    if (!ok || tx_log.size() - tb != 2) begin
      bad++; $display("FAIL burst_read_count: got %0d, want 2", tx_log.size() - tb);
    end else begin
      total++;
      if (tx_log[tb] !== 8'hAA || tx_log[tb + 1] !== 8'hBB) begin
        bad++; $display("FAIL burst_read_data: got %h %h, want aa bb", tx_log[tb], tx_log[tb + 1]);
      end
    end
    total++;
    if (full_viol != fv) begin bad++; $display("FAIL burst_read_full: got %0d strobes while full, want 0", full_viol - fv); end
  endtask

  task automatic test_alu;
    int wb, tb, fb;
    bit ok;
    wb = wr_log.size(); tb = tx_log.size(); fb = fun_log.size();
    send_byte(8'hCC, 0); send_byte(8'h07, 0); send_byte(8'h05, 0); send_byte(8'h00, 0);
    wait_idle(ok);
    model_regs[0] = 8'h07; model_regs[1] = 8'h05;
    total++;
    if (!ok || wr_log.size() - wb != 2 || tx_log.size() - tb != 2 || fun_log.size() - fb != 1) begin
      bad++; $display("FAIL alu_counts: got wr=%0d tx=%0d en=%0d, want 2 2 1",
                      wr_log.size() - wb, tx_log.size() - tb, fun_log.size() - fb);
    end else begin
      total++;
      if (wr_log[wb] !== {4'h0, 8'h07} || wr_log[wb + 1] !== {4'h1, 8'h05}) begin
        bad++; $display("FAIL alu_operands: got %h %h, want 007 105", wr_log[wb], wr_log[wb + 1]);
      end
      total++;
      if (fun_log[fb] !== 4'h0) begin bad++; $display("FAIL alu_fun: got %h, want 0", fun_log[fb]); end
      total++;
      if (tx_log[tb] !== 8'h0C || tx_log[tb + 1] !== 8'h00) begin
        bad++; $display("FAIL alu_result: got %h %h, want 0c 00", tx_log[tb], tx_log[tb + 1]);
      end
      total++;
      if ({wr_clk[wb], wr_clk[wb + 1], tx_clk[tb], tx_clk[tb + 1], CLK_EN} !== 5'b01110) begin
        bad++; $display("FAIL alu_clk_en: got %b, want 01110",
                        {wr_clk[wb], wr_clk[wb + 1], tx_clk[tb], tx_clk[tb + 1], CLK_EN});
      end
    end
  endtask

  task automatic test_timeout;
    int wb, tb, e0, sc;
    bit ok, seen;
    wb = wr_log.size(); tb = tx_log.size(); e0 = err_cnt;
    send_byte(8'hAA, 0);
    send_byte(8'h05, 0);
    sc = strobe_cyc;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (err_cnt != e0) begin seen = 1'b1; break; end
    end
    wait_idle(ok);
    total++;
    if (!seen || err_cyc != sc + TO + 1) begin
      bad++; $display("FAIL timeout_cycle: got err at %0d (seen=%0d), want %0d", err_cyc, seen, sc + TO + 1);
    end
    total++;
    if (wr_log.size() != wb || busy !== 1'b0) begin
      bad++; $display("FAIL timeout_abort: got %0d writes busy=%b, want 0 writes busy=0", wr_log.size() - wb, busy);
    end
`ifdef CMD_ERR_RESP_EN
    total++;
    if (tx_log.size() - tb != 1 || tx_log[tb] !== 8'hE0) begin
      bad++; $display("FAIL timeout_resp: got %0d bytes, want one e0", tx_log.size() - tb);
    end
`else
    total++;
    if (tx_log.size() != tb) begin bad++; $display("FAIL timeout_tx: got %0d bytes, want 0", tx_log.size() - tb); end
`endif
  endtask

  task automatic test_bad_opcode;
    int e0, wb;
    bit ok;
    e0 = err_cnt; wb = wr_log.size();
    send_byte(8'h42, 0);
`ifndef CMD_ERR_RESP_EN
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL bad_opcode_busy: got %b, want 0", busy); end
`endif
    wait_idle(ok);
    total++;
    if (err_cnt != e0 + 1 || wr_log.size() != wb) begin
      bad++; $display("FAIL bad_opcode_err: got %0d pulses %0d writes, want 1 0", err_cnt - e0, wr_log.size() - wb);
    end
  endtask

  task automatic test_random;
    int wb, tb, fb, kind, n;
    bit ok;
    logic [7:0] fr [$];
    logic [11:0] ew [$];
    logic [7:0] et [$];
    logic [3:0] ef [$];
    logic [7:0] a, c, d, x, y;
    logic [3:0] f;
    logic [15:0] r;
    rand_en = 1'b1;
    for (int fidx = 0; fidx < 41; fidx++) begin
      fr.delete(); ew.delete(); et.delete(); ef.delete();
      kind = (fidx == 0) ? 9 : $urandom_range(0, 5);
      a = 8'($urandom_range(0, 15));
      c = 8'($urandom_range(0, 3));
      case (kind)
        0: begin
          d = 8'($urandom);
          fr = '{8'hAA, a, d};
          ew.push_back({a[3:0], d}); model_regs[a[3:0]] = d;
        end
        1, 9: begin
          if (kind == 9) begin a = 8'h00; c = 8'h0F; end
          fr = '{8'hEE, a, c};
          for (int i = 0; i <= int'(c); i++) begin
            d = 8'($urandom);
            fr.push_back(d);
            ew.push_back({4'(a + i), d}); model_regs[4'(a + i)] = d;
          end
        end
        2: begin
          fr = '{8'hBB, a};
          et.push_back(model_regs[a[3:0]]);
        end
        3: begin
          fr = '{8'hFF, a, c};
          for (int i = 0; i <= int'(c); i++) et.push_back(model_regs[4'(a + i)]);
        end
        default: begin
          f = 4'($urandom_range(0, 4));
          if (kind == 4) begin
            x = 8'($urandom); y = 8'($urandom);
            fr = '{8'hCC, x, y, {4'h0, f}};
            ew.push_back({4'h0, x}); ew.push_back({4'h1, y});
            model_regs[0] = x; model_regs[1] = y;
          end else begin
            fr = '{8'hDD, {4'h0, f}};
          end
          r = alu_ref(model_regs[0], model_regs[1], f);
          et.push_back(r[7:0]); et.push_back(r[15:8]);
          ef.push_back(f);
        end
      endcase
      wb = wr_log.size(); tb = tx_log.size(); fb = fun_log.size();
      for (int i = 0; i < fr.size(); i++) send_byte(fr[i], $urandom_range(0, 3));
      wait_idle(ok);
      n = wr_log.size() - wb;
      total++;
      if (!ok || n != ew.size() || tx_log.size() - tb != et.size() || fun_log.size() - fb != ef.size()) begin
        bad++; $display("FAIL rand%0d_counts kind=%0d: got wr=%0d tx=%0d en=%0d, want %0d %0d %0d", fidx, kind,
                        n, tx_log.size() - tb, fun_log.size() - fb, ew.size(), et.size(), ef.size());
      end else begin
        for (int i = 0; i < ew.size(); i++) begin
          total++;
          if (wr_log[wb + i] !== ew[i]) begin bad++; $display("FAIL rand%0d_wr%0d: got %h, want %h", fidx, i, wr_log[wb + i], ew[i]); end
        end
        for (int i = 0; i < et.size(); i++) begin
          total++;
          if (tx_log[tb + i] !== et[i]) begin bad++; $display("FAIL rand%0d_tx%0d: got %h, want %h", fidx, i, tx_log[tb + i], et[i]); end
        end
        for (int i = 0; i < ef.size(); i++) begin
          total++;
          if (fun_log[fb + i] !== ef[i]) begin bad++; $display("FAIL rand%0d_fun: got %h, want %h", fidx, fun_log[fb + i], ef[i]); end
        end
      end
    end
    rand_en = 1'b0;
    repeat (2) @(negedge CLK);
    total++;
    if (full_viol != 0) begin bad++; $display("FAIL rand_full_gate: got %0d strobes while full, want 0", full_viol); end
  endtask

  task automatic test_reset_mid;
    int wb;
    wb = wr_log.size();
    send_byte(8'hEE, 0); send_byte(8'h03, 0); send_byte(8'h05, 0);
    send_byte(8'h5A, 0); send_byte(8'hA5, 0);
    @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    total++;
    if ({Wr_En, Rd_En, Address, Wr_Data, ALU_EN, ALU_FUN, CLK_EN, TX_D_VLD, TX_P_DATA, cmd_err, busy} !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got %b, want all zero",
               {Wr_En, Rd_En, Address, Wr_Data, ALU_EN, ALU_FUN, CLK_EN, TX_D_VLD, TX_P_DATA, cmd_err, busy});
    end
    @(negedge CLK);
    RST = 1'b1;
    repeat (6) @(negedge CLK);
    total++;
    if (wr_log.size() - wb != 2 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_abort: got %0d writes busy=%b, want 2 writes busy=0", wr_log.size() - wb, busy);
    end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_burst_wrap;
    test_burst_read;
    test_alu;
    test_timeout;
    test_bad_opcode;
    test_random;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
